double_op_arbiter: RTL

//   Shares one fixed-latency pipelined 64-bit double operator (double_neg, double_abs, ...) between
//   NUM_REQ requesters.
//   - Round-robin grants one operand per cycle into the shared unit.
//   - A tag pipeline tracks the owner of each in-flight operand.
//   - Each result is returned to its owner through a one-entry buffer with a valid/ready handshake.

---
 rtl/double_arb_pkg.sv | 23 ++
 rtl/double_arb_rr.sv | 32 +++
 rtl/double_op_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/double_arb_pkg.sv
// rtl/double_arb_pkg.sv - shared types, widths and bus helpers for double_op_arbiter
package double_arb_pkg;

  localparam int DOUBLE_W = 64;
  localparam int MAX_REQ  = 8;
  localparam int OWNER_W  = 3;
  localparam int BUS_W    = MAX_REQ * DOUBLE_W;

  function automatic int tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Owner field sized for the largest supported requester count.
  typedef struct packed {
    logic               valid;
    logic [OWNER_W-1:0] owner;
  } tag_t;

  function automatic logic [DOUBLE_W-1:0] word_at(input logic [BUS_W-1:0] bus, input int idx);
    return bus[idx*DOUBLE_W +: DOUBLE_W];
  endfunction

endpackage

// File: rtl/double_arb_rr.sv
// rtl/double_arb_rr.sv - combinational round-robin picker, searches upward from ptr with wrap
import double_arb_pkg::*;

module double_arb_rr #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = tag_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (!grant_any && eligible[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/double_op_arbiter.sv
// rtl/double_op_arbiter.sv - shares one pipelined 64-bit double operator among NUM_REQ requesters
// Optional per-requester accept counters on grant_cnt when DOUBLE_ARB_COUNT_EN is defined.
import double_arb_pkg::*;

module double_op_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DOUBLE_W-1:0] req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DOUBLE_W-1:0]         op_a,
  input  logic [DOUBLE_W-1:0]         op_z,
  output logic [NUM_REQ-1:0]          res_valid,
  output logic [NUM_REQ*DOUBLE_W-1:0] res_data,
  input  logic [NUM_REQ-1:0]          res_ready
`ifdef DOUBLE_ARB_COUNT_EN
  ,
  output logic [NUM_REQ*16-1:0]       grant_cnt
`endif
);

  localparam int PTR_W = tag_w(NUM_REQ);

  logic [NUM_REQ-1:0] busy;
  logic [PTR_W-1:0]   ptr;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;
  logic [BUS_W-1:0]   req_bus;
  logic [NUM_REQ-1:0] consume;
  tag_t               out_tag;

  // One extra stage over LATENCY accounts for op_a itself being registered.
  tag_t tag_pipe [LATENCY+1];

  assign eligible  = req_valid & ~busy;
  assign req_bus   = BUS_W'(req_data);
  assign consume   = res_valid & res_ready;
  assign out_tag   = tag_pipe[LATENCY];
  assign req_ready = rst ? '0 : grant;

  double_arb_rr #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .eligible  (eligible),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a      <= '0;
      ptr       <= '0;
      busy      <= '0;
      res_valid <= '0;
      res_data  <= '0;
      for (int s = 0; s <= LATENCY; s++) begin
        tag_pipe[s] <= '0;
      end
    end else begin
      if (grant_any) begin
        op_a        <= word_at(req_bus, int'(grant_idx));
        tag_pipe[0] <= '{valid: 1'b1, owner: OWNER_W'(grant_idx)};
        ptr         <= PTR_W'((int'(grant_idx) + 1) % NUM_REQ);
      end else begin
        op_a        <= '0;
        tag_pipe[0] <= '0;
      end
      for (int s = 1; s <= LATENCY; s++) begin
        tag_pipe[s] <= tag_pipe[s-1];
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        if (grant[j]) begin
          busy[j] <= 1'b1;
        end else if (consume[j]) begin
          busy[j] <= 1'b0;
        end
        // A single outstanding operand per owner means capture and consume never collide.
        if (out_tag.valid && out_tag.owner == OWNER_W'(j)) begin
          res_valid[j]                       <= 1'b1;
          res_data[j*DOUBLE_W +: DOUBLE_W] <= op_z;
        end else if (consume[j]) begin
          res_valid[j] <= 1'b0;
        end
      end
    end
  end

`ifdef DOUBLE_ARB_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
    end else begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (grant[j]) begin
          grant_cnt[j*16 +: 16] <= grant_cnt[j*16 +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule
